int_subtractor_seq: RTL and testbench
=====================================

INT_SUBTRACTOR_SEQ -- requirements
Module: int_subtractor_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8: bits processed per cycle; DATA_WIDTH SHALL be an integer multiple of CHUNK_WIDTH; NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 data_a  input  DATA_WIDTH  minuend.
REQ-009 data_b  input  DATA_WIDTH  subtrahend.
REQ-010 borrow_in  input  1  borrow into the LSB.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 diff  output  DATA_WIDTH  data_a - data_b - borrow_in, mod 2^DATA_WIDTH.
REQ-014 borrow_out  output  1  1 when unsigned data_a < data_b + borrow_in.
REQ-015 overflow  output  1  signed overflow flag; present only with INT_SUB_OVF_EN.

Function
REQ-016 SHALL implement states IDLE, BUSY and DONE.
REQ-017 IDLE: in_ready=1; an input handshake (in_valid & in_ready) SHALL register data_a, data_b and borrow_in, clear the chunk index, and go to BUSY.
REQ-018 BUSY: in_ready=0; each cycle SHALL subtract one CHUNK_WIDTH slice (LSB slice first) with a registered borrow chained from the previous slice, and write the result into the diff register.
REQ-019 After NCHUNK BUSY cycles the state SHALL become DONE, with borrow_out equal to the borrow out of the top slice.
REQ-020 Latency: out_valid SHALL rise exactly NCHUNK cycles after the input-handshake edge (4 cycles at default parameters).
REQ-021 DONE: out_valid=1; diff, borrow_out and overflow SHALL hold stable until out_valid & out_ready, then the state SHALL return to IDLE.
REQ-022 in_ready SHALL be 0 in DONE; a new operand set SHALL NOT be accepted in the same cycle as the output handshake.
REQ-023 Operand inputs SHALL be ignored outside the input handshake; changes during BUSY SHALL NOT affect the result.
REQ-024 NCHUNK=1 SHALL be legal, giving a 1-cycle BUSY phase.
REQ-025 Results SHALL be bit-exact to the full-width subtraction for all operands, including a==b with borrow_in=1 (diff all-ones, borrow_out=1).

Reset
REQ-026 rst=1 SHALL force state IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0 and overflow=0 at the next rising edge.
REQ-027 Reset asserted during BUSY or DONE SHALL discard the operation in progress; no stale out_valid SHALL appear afterwards.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro INT_SUB_OVF_EN, when defined, SHALL add port overflow, set at DONE when sign(a) != sign(b) and sign(diff) != sign(a), treating operands as two's complement.
REQ-030 Without INT_SUB_OVF_EN, the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (DATA_WIDTH=32, CHUNK_WIDTH=8)
REQ-031 a=5, b=3, bin=0 -> after 4 cycles out_valid=1, diff=0x00000002, borrow_out=0.
REQ-032 a=0, b=1, bin=0 -> diff=0xFFFFFFFF, borrow_out=1; a=b=0x1234, bin=1 -> diff=0xFFFFFFFF, borrow_out=1.
REQ-033 INT_SUB_OVF_EN defined: a=0x80000000, b=1 -> diff=0x7FFFFFFF, overflow=1, borrow_out=0; a=7, b=2 -> overflow=0.
REQ-034 out_ready held low 3 cycles in DONE -> out_valid and diff stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-035 rst pulsed in the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, diff=0; a following 9-4 operation returns 5.
REQ-036 Operands toggled during BUSY after accepting a=100, b=40 -> diff=60.

Source files
------------

// File: rtl/int_subtractor_seq.sv
// Multi-cycle subtractor: one CHUNK_WIDTH slice per cycle, LSB first.
// Optional signed-overflow port enabled by defining INT_SUB_OVF_EN.
module int_subtractor_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  borrow_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow_out
`ifdef INT_SUB_OVF_EN
  ,
  output logic                  overflow
`endif
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic [IW-1:0] idx_q, idx_d;
  logic bor_q, bor_d;
  logic [CHUNK_WIDTH:0] slice_w;
`ifdef INT_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      bor_q   <= 1'b0;
`ifdef INT_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
      bor_q   <= bor_d;
`ifdef INT_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state: accept in IDLE, walk slices in BUSY, wait for consumer in DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (idx_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, then one borrow-chained slice per cycle
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    diff_d = diff_q;
    idx_d  = idx_q;
    bor_d  = bor_q;
`ifdef INT_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    slice_w = {1'b0, a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH]}
            - {1'b0, b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH]}
            - {{CHUNK_WIDTH{1'b0}}, bor_q};
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = data_a;
          b_d   = data_b;
          bor_d = borrow_in;
          idx_d = '0;
`ifdef INT_SUB_OVF_EN
          ovf_d = 1'b0;
`endif
        end
      end
      BUSY: begin
        diff_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = slice_w[CHUNK_WIDTH-1:0];
        bor_d = slice_w[CHUNK_WIDTH];
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef INT_SUB_OVF_EN
          ovf_d = (a_q[MSB] ^ b_q[MSB]) & (diff_d[MSB] ^ a_q[MSB]);
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    diff       = diff_q;
    borrow_out = bor_q;
`ifdef INT_SUB_OVF_EN
    overflow   = ovf_q;
`endif
  end

endmodule

// File: tb/tb_int_subtractor_seq.sv
// Directed bench for int_subtractor_seq at DATA_WIDTH=32, CHUNK_WIDTH=8.
// Define INT_SUB_OVF_EN to also exercise the overflow port.
module tb_int_subtractor_seq;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic borrow_in;
  logic out_valid;
  logic out_ready;
  logic [31:0] diff;
  logic borrow_out;
`ifdef INT_SUB_OVF_EN
  logic overflow;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  int_subtractor_seq #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_a(data_a),
    .data_b(data_b),
    .borrow_in(borrow_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .borrow_out(borrow_out)
`ifdef INT_SUB_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one operation and wait for its result (left in DONE).
  task automatic start_and_wait(input string tag, input logic [31:0] a,
                                input logic [31:0] b, input logic bin,
                                input bit toggle);
    int k;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    data_a    = a;
    data_b    = b;
    borrow_in = bin;
    @(negedge clk);
    in_valid  = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      if (toggle) begin
        data_a    = $urandom;
        data_b    = $urandom;
        borrow_in = ~borrow_in;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, 4);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic bin,
                       input logic [31:0] ed, input logic eb,
                       input logic eo, input bit toggle);
    start_and_wait(tag, a, b, bin, toggle);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, eb);
`ifdef INT_SUB_OVF_EN
    chk({tag, "_ovf"}, overflow, eo);
`else
    if (eo === 1'bx) $display("note: unexpected x flag in %s", tag);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_a    = '0;
    data_b    = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    do_op("v5m3", 32'd5, 32'd3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
    do_op("v0m1", 32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    do_op("eqbin", 32'h1234, 32'h1234, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0,
          1'b0);
    do_op("chunkcarry", 32'h100, 32'h1, 1'b0, 32'hFF, 1'b0, 1'b0, 1'b0);
    do_op("mixed", 32'h12345678, 32'h87654321, 1'b0, 32'h8ACF1357, 1'b1,
          1'b1, 1'b0);
    do_op("ovf", 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1,
          1'b0);
    do_op("noovf", 32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    do_op("toggle", 32'd100, 32'd40, 1'b0, 32'd60, 1'b0, 1'b0, 1'b1);

    // Hold the result with out_ready low, offering new operands meanwhile
    start_and_wait("stall", 32'd50, 32'd8, 1'b0, 1'b0);
    in_valid = 1'b1;
    data_a   = 32'd1;
    data_b   = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_diff", diff, 32'd42);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release", {out_valid, in_ready}, 2'b01);

    // Reset in the second BUSY cycle discards the operation
    @(negedge clk);
    in_valid = 1'b1;
    data_a   = 32'd77;
    data_b   = 32'd11;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end
    do_op("after_rst", 32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
